// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a common-cathode 7-segment display.
//
// Segment patterns are double-buffered. The host writes a staged copy with
// frame_wr, and the display only ever reads the shadow copy. The shadow copy
// is reloaded only at the start of a scan frame, so one frame never mixes old
// and new data. Each digit gets BLANK dead-time cycles and then DWELL drive
// cycles, and digits are scanned from index 0 up to NDIGITS-1.
//
// Ports
//   clk          system clock; all logic is on the rising edge
//   rst          synchronous, active-high reset
//   en           scan enable; 0 blanks the display and parks the scanner
//   frame_wr     one-cycle write strobe for frame_data
//   frame_data   packed {dp,g,f,e,d,c,b,a} per digit; digit 0 is in [7:0]
//   frame_busy   high while a written frame waits for its swap
//   frame_ack    one-cycle pulse when a staged frame becomes visible
//   frame_start  one-cycle pulse on the first cycle of each scan frame
//   seg_out      active-high segment drive
//   dig_n        active-low digit select; at most one bit is low
module display_scan #(
    parameter int NDIGITS = 4,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   frame_wr,
    input  logic [8*NDIGITS-1:0]   frame_data,
    output logic                   frame_busy,
    output logic                   frame_ack,
    output logic                   frame_start,
    output logic [7:0]             seg_out,
    output logic [NDIGITS-1:0]     dig_n
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*NDIGITS-1:0]   staged_q, staged_d;
    logic [8*NDIGITS-1:0]   shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic [7:0]             seg_q, seg_d;
    logic [NDIGITS-1:0]     dig_n_q, dig_n_d;
    logic                   ack_q, ack_d;
    logic                   start_q, start_d;
    logic                   swap;

    // Split the shadow copy into one pattern per digit.
    logic [7:0] digit [NDIGITS];
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        assign digit[gi] = shadow_q[gi*8 +: 8];
    end

    // Next-state logic. The outputs are derived from the next state, so they
    // register on the same edge as the state and have no combinational path
    // from the inputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        swap    = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    swap    = 1'b1;
                end
                S_BLANK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IW'(NDIGITS - 1)) begin
                            // Wrapping to digit 0 starts a new frame, which
                            // is the only place a swap may happen.
                            idx_d = '0;
                            swap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A write on the swap edge wins: the swap consumes the old staged
        // value, and the new data stays pending for the next frame.
        staged_d  = frame_wr ? frame_data : staged_q;
        pending_d = frame_wr ? 1'b1 : (swap ? 1'b0 : pending_q);
        shadow_d  = (swap && pending_q) ? staged_q : shadow_q;

        start_d = swap;
        ack_d   = swap & pending_q;

        // The shadow copy is stable whenever the next state is DRIVE.
        seg_d   = (state_d == S_DRIVE) ? digit[idx_d] : 8'h00;
        dig_n_d = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (state_d == S_DRIVE && idx_d == IW'(i)) begin
                dig_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            staged_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= 8'h00;
            dig_n_q   <= '1;
            ack_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            staged_q  <= staged_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dig_n_q   <= dig_n_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
        end
    end

    assign frame_busy  = pending_q;
    assign frame_ack   = ack_q;
    assign frame_start = start_q;
    assign seg_out     = seg_q;
    assign dig_n       = dig_n_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed bench for display_scan with NDIGITS=4, DWELL=4 and
// BLANK=1, which gives a 20-cycle frame. Inputs are driven on the falling edge
// and outputs are checked on the falling edge that follows the next rising edge.
module tb_display_scan;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int BL = 1;
    localparam int PERIOD = ND * (BL + DW);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            frame_wr = 1'b0;
    logic [8*ND-1:0] frame_data = '0;
    logic            frame_busy;
    logic            frame_ack;
    logic            frame_start;
    logic [7:0]      seg_out;
    logic [ND-1:0]   dig_n;

    int checks = 0;
    int passes = 0;
    logic pend_m = 1'b0;
    logic wr_issued = 1'b0;

    display_scan #(.NDIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .frame_wr    (frame_wr),
        .frame_data  (frame_data),
        .frame_busy  (frame_busy),
        .frame_ack   (frame_ack),
        .frame_start (frame_start),
        .seg_out     (seg_out),
        .dig_n       (dig_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_off(input string tag, input logic exp_busy);
        chk({tag, "_seg"}, 32'(seg_out), 32'h0);
        chk({tag, "_dig"}, 32'(dig_n), 32'hF);
        chk({tag, "_start"}, 32'(frame_start), 32'h0);
        chk({tag, "_ack"}, 32'(frame_ack), 32'h0);
        chk({tag, "_busy"}, 32'(frame_busy), 32'(exp_busy));
    endtask

    // Step through ncyc cycles of one frame, starting at its first BLANK cycle.
    // Up to two writes are issued after the check at cycle w1/w2 (-1 means none).
    task automatic scan_frame(input string name, input logic [31:0] exp_frame,
                              input logic exp_ack, input int ncyc,
                              input int w1, input logic [31:0] d1,
                              input int w2, input logic [31:0] d2);
        int d;
        int ph;
        logic [7:0] e_seg;
        logic [3:0] e_dig;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            frame_wr = 1'b0;
            // The swap edge clears pending unless a write landed on that edge.
            if (wr_issued) pend_m = 1'b1;
            else if (c == 0) pend_m = 1'b0;
            wr_issued = 1'b0;
            d  = c / (BL + DW);
            ph = c % (BL + DW);
            e_dig = 4'hF;
            if (ph < BL) begin
                e_seg = 8'h00;
            end else begin
                e_seg = exp_frame[d*8 +: 8];
                e_dig[d] = 1'b0;
            end
            chk($sformatf("%s_c%0d_seg", name, c), 32'(seg_out), 32'(e_seg));
            chk($sformatf("%s_c%0d_dig", name, c), 32'(dig_n), 32'(e_dig));
            chk($sformatf("%s_c%0d_start", name, c), 32'(frame_start), 32'(c == 0));
            chk($sformatf("%s_c%0d_ack", name, c), 32'(frame_ack), 32'((c == 0) && exp_ack));
            chk($sformatf("%s_c%0d_busy", name, c), 32'(frame_busy), 32'(pend_m));
            if (c == w1) begin
                frame_wr = 1'b1; frame_data = d1; wr_issued = 1'b1;
            end else if (c == w2) begin
                frame_wr = 1'b1; frame_data = d2; wr_issued = 1'b1;
            end
        end
        $display("frame %s: %0d cycles stepped, %0d/%0d checks so far", name, ncyc, passes, checks);
    endtask

    initial begin
        // Reset with a write and enable present: both must be ignored.
        en = 1'b1; frame_wr = 1'b1; frame_data = 32'hDEADBEEF;
        @(negedge clk);
        en = 1'b0; frame_wr = 1'b0;
        @(negedge clk);
        chk_off("reset", 1'b0);
        $display("reset: checked outputs at reset values");
        rst = 1'b0;

        // First frame: 0x7F_06_5B_3F goes visible with ack on the first frame_start.
        frame_data = 32'h7F065B3F; frame_wr = 1'b1;
        @(negedge clk);
        frame_wr = 1'b0;
        chk_off("idle_after_wr", 1'b1);
        pend_m = 1'b1;
        en = 1'b1;
        scan_frame("f1", 32'h7F065B3F, 1'b1, PERIOD, -1, '0, -1, '0);

        // Write during the DRIVE of idx 1 (cycle 7): the current frame is unchanged.
        scan_frame("f2", 32'h7F065B3F, 1'b0, PERIOD, 7, 32'h00000071, -1, '0);
        // The new data becomes visible next frame; A then B are both written before the swap.
        scan_frame("f3", 32'h00000071, 1'b1, PERIOD, 3, 32'h11223344, 10, 32'h55667788);
        // Only B is shown. D is written mid-frame, then C on the last cycle (the swap edge).
        scan_frame("f4", 32'h55667788, 1'b1, PERIOD, 5, 32'h0A0B0C0D, 19, 32'h01020304);
        // D is swapped in while C stays pending (busy is 1 all frame).
        scan_frame("f5", 32'h0A0B0C0D, 1'b1, PERIOD, -1, '0, -1, '0);
        scan_frame("f6", 32'h01020304, 1'b1, PERIOD, -1, '0, -1, '0);

        // Drop en on the first DRIVE cycle of idx 2 (cycle 11).
        scan_frame("f7", 32'h01020304, 1'b0, 12, -1, '0, -1, '0);
        en = 1'b0;
        @(negedge clk);
        chk_off("en_drop", 1'b0);
        @(negedge clk);
        chk_off("en_idle", 1'b0);
        $display("en drop: display blanked for 2 cycles");
        en = 1'b1;
        scan_frame("f8", 32'h01020304, 1'b0, PERIOD, -1, '0, -1, '0);

        // Write E at cycle 2, then reset during the DRIVE of idx 1 while E is pending.
        scan_frame("f9", 32'h01020304, 1'b0, 8, 2, 32'h12345678, -1, '0);
        rst = 1'b1;
        @(negedge clk);
        chk_off("rst_mid", 1'b0);
        frame_wr = 1'b1; frame_data = 32'hFFFFFFFF;
        @(negedge clk);
        frame_wr = 1'b0;
        chk_off("rst_wr_lost", 1'b0);
        $display("mid-frame reset: outputs at reset values");
        pend_m = 1'b0; wr_issued = 1'b0;
        rst = 1'b0;
        scan_frame("f10", 32'h00000000, 1'b0, PERIOD, -1, '0, -1, '0);

        en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
